// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states and Booth pair codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth recoding of {Q[0], q_m1}; 2'b11 is also a no-op and falls to the default arm.
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_ctrl_dff.sv
// Single-bit flop with asynchronous active-low clear.
// Latency: 1 cycle from d to q.
// Backpressure: none; the caller muxes d to hold its value.
module booth_mult_ctrl_dff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Plain storage bit, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> signed 2*WIDTH product.
// Latency: WIDTH+1 cycles from accept to result_valid (1 cycle for zero operands with BOOTH_MULT_EARLY_EXIT_EN).
// Backpressure: start_ready only in IDLE; the product is held in DONE until result_ready.
module booth_mult_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    state_t          state;
    logic [WIDTH:0]  acc;      // A: one guard bit so subtracting the most negative M cannot overflow
    logic [WIDTH-1:0] mq;      // Q: multiplier, shifted out as product low half shifts in
    logic [WIDTH-1:0] mcand;   // M: captured multiplicand
    logic [CW-1:0]   count;
    logic            q_m1;
    logic            q_m1_d;
    logic            load;
    logic            step;
    logic            zero_op;
    logic [WIDTH:0]  msext;
    logic [WIDTH:0]  sum;
    logic [1:0]      pair;

    assign load = (state == IDLE) && start_valid;
    assign step = (state == CALC);

`ifdef BOOTH_MULT_EARLY_EXIT_EN
    // A zero operand makes the product zero without iterating.
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    // q_m1 source: cleared on load, takes the bit shifted out of Q on each step, else holds.
    always_comb begin
        q_m1_d = q_m1;
        if (load) begin
            q_m1_d = 1'b0;
        end else if (step) begin
            q_m1_d = mq[0];
        end
    end

    booth_mult_ctrl_dff u_q_m1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (q_m1_d),
        .q     (q_m1)
    );

    // Booth add/subtract of the sign-extended multiplicand into A before the shift.
    always_comb begin
        msext = {mcand[WIDTH-1], mcand};
        pair  = {mq[0], q_m1};
        sum   = acc;
        case (pair)
            BOOTH_ADD: sum = acc + msext;
            BOOTH_SUB: sum = acc - msext;
            default:   sum = acc;
        endcase
    end

    // Controller and datapath registers; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            mq           <= '0;
            mcand        <= '0;
            count        <= '0;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        mcand       <= multiplicand;
                        acc         <= '0;
                        mq          <= zero_op ? '0 : multiplier;
                        count       <= COUNT_INIT;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (zero_op) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= {sum[WIDTH], sum[WIDTH:1]};
                    mq    <= {sum[0], mq[WIDTH-1:1]};
                    count <= count - 1'b1;
                    if (count == COUNT_LAST) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        start_ready  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    start_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Product is the low 2*WIDTH bits of {A,Q}; the guard bit of A is dropped.
    assign result = {acc[WIDTH-1:0], mq};

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Bench for booth_mult_ctrl: directed cases plus randomized signed pairs with result stalls.
// Latency: n/a.
// Backpressure: result_ready driven by the monitor (always, random, or held low).
module tb_booth_mult_ctrl;

    localparam int W = 8;

    logic            clk;
    logic            rst_n;
    logic            start_valid;
    logic            start_ready;
    logic [W-1:0]    multiplicand;
    logic [W-1:0]    multiplier;
    logic            result_valid;
    logic            result_ready;
    logic [2*W-1:0]  result;
    logic            busy;

    int              pass_cnt  = 0;
    int              total_cnt = 0;
    int              ready_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
    logic [2*W-1:0]  exp_q[$];

    booth_mult_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: decides result_ready each cycle and checks the product on every handshake.
    initial begin
        logic rdy;
        logic [2*W-1:0] e;
        result_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b0;
            endcase
            result_ready = rdy;
            if (rst_n && result_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(result), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e));
                end
            end
        end
    end

    // Present one pair at a negedge, wait for acceptance, queue the expected product.
    task automatic send(input logic [W-1:0] m, input logic [W-1:0] q, input logic [2*W-1:0] e);
        int guard = 0;
        while (!start_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("start_ready_timeout", 32'(start_ready), 32'd1);
        exp_q.push_back(e);
        start_valid  = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk);
        @(negedge clk);
        start_valid  = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Called right after send(): counts busy cycles and the cycle result_valid first appears.
    task automatic measure(input string tag, input int exp_lat, input int exp_busy);
        int n = 0;
        int lat = 0;
        while (busy && n < 100) begin
            n++;
            if (result_valid && lat == 0) lat = n;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [W-1:0]   ms;
        logic signed [W-1:0]   qs;
        logic signed [2*W-1:0] p;
        int exp_early_lat;
`ifdef BOOTH_MULT_EARLY_EXIT_EN
        exp_early_lat = 1;
`else
        exp_early_lat = W + 1;
`endif
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed products with latency/busy timing on the first.
        send(8'd3, 8'd5, 16'h000F);
        measure("m3q5", W + 1, W + 1);
        drain();
        send(8'hF9, 8'd6, 16'hFFD6);
        send(8'h80, 8'h80, 16'h4000);
        send(8'h80, 8'h7F, 16'hC080);
        drain();

        // Stall in DONE: product and start_ready must hold, stray start_valid ignored.
        ready_mode = 2;
        send(8'd25, 8'hFD, 16'hFFB5);
        begin
            int g = 0;
            while (!result_valid && g < 50) begin
                @(negedge clk);
                g++;
            end
            check("stall_valid_seen", 32'(result_valid), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_result_hold", 32'(result), 32'hFFB5);
            check("stall_start_ready", 32'(start_ready), 32'd0);
            if (i == 1) begin
                start_valid  = 1'b1;
                multiplicand = 8'd9;
                multiplier   = 8'd9;
            end else begin
                start_valid = 1'b0;
            end
            @(negedge clk);
        end
        start_valid = 1'b0;
        ready_mode  = 0;
        drain();
        repeat (3) @(negedge clk);
        check("post_stall_idle_ready", 32'(start_ready), 32'd1);
        check("post_stall_no_extra", 32'(result_valid), 32'd0);

        // Reset during CALC cycle 4 discards the transaction.
        send(8'd100, 8'hB3, 16'hDEAD);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_start_ready", 32'(start_ready), 32'd1);
        check("midrst_result_valid", 32'(result_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'd2, 8'd2, 16'h0004);
        drain();

        // Zero operand: short-circuit only when the early-exit build is selected.
        send(8'd0, 8'hFB, 16'h0000);
        measure("zero_op", exp_early_lat, exp_early_lat);
        drain();

        // Randomized signed pairs against arithmetic reference, with random stalls.
        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0:       ms = -8'sd128;
                1:       ms = 8'sd127;
                2:       ms = 8'sd0;
                default: ms = W'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0:       qs = -8'sd128;
                1:       qs = 8'sd0;
                default: qs = W'($urandom);
            endcase
            p = ms * qs;
            send(ms, qs, p);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        ready_mode = 0;
        drain();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
